// File: rtl/span_painter_if.sv
// span_painter_if: PRAM queue pointers/data and frame-buffer pixel write signals of the span painter
interface span_painter_if;
  logic [9:0] wrtPtr;
  logic [15:0] PRAMdata;
  logic [9:0] rdPtr;
  logic full;
  logic [15:0] addr;
  logic [2:0] data;
  logic we;
  modport master(input wrtPtr, PRAMdata, output rdPtr, full, addr, data, we);
  modport slave(output wrtPtr, PRAMdata, input rdPtr, full, addr, data, we);
endinterface

// File: rtl/span_painter.sv
// span_painter: turns two-word span commands from the PRAM ring into single-pixel frame-buffer writes
module span_painter #(
  parameter int WIDTH = 160,
  parameter int LINES = 115,
  parameter int SPECIAL_BASE = 36800,
  parameter int BACK_OFFSET = 18400
) (
  input logic clk,
  input logic reset,
  span_painter_if.master bus
);
  typedef enum logic [2:0] {IDLE, LD0, WT1, LD1, DRAW} state_t;
  localparam logic [6:0] SPECIAL_LINE = 7'(LINES);
  localparam logic [6:0] DROP_LINE = 7'(LINES + 5);
  localparam logic [7:0] MAX_X = 8'(WIDTH - 1);
  state_t state, state_n;
  logic [9:0] rd_ptr, occ;
  logic buf_sel;
  logic [6:0] line, rel;
  logic [2:0] color;
  logic [7:0] x, x1, lo, hi, x0_c, x1_c;
  logic [15:0] base, base_n, row;
  logic drop;
  assign occ = bus.wrtPtr - rd_ptr;
  assign bus.full = bus.wrtPtr + 10'd1 == rd_ptr;
  assign bus.rdPtr = rd_ptr;
  assign lo = bus.PRAMdata[15:8] < bus.PRAMdata[7:0] ? bus.PRAMdata[15:8] : bus.PRAMdata[7:0];
  assign hi = bus.PRAMdata[15:8] < bus.PRAMdata[7:0] ? bus.PRAMdata[7:0] : bus.PRAMdata[15:8];
  assign x0_c = lo > MAX_X ? MAX_X : lo;
  assign x1_c = hi > MAX_X ? MAX_X : hi;
  assign drop = line >= DROP_LINE;
  assign rel = line >= SPECIAL_LINE ? line - SPECIAL_LINE : line;
  assign row = ({9'd0, rel} << 7) + ({9'd0, rel} << 5);
  assign base_n = row + (line >= SPECIAL_LINE ? 16'(SPECIAL_BASE) : buf_sel ? 16'(BACK_OFFSET) : 16'd0);
  always_comb
    state_n = state == IDLE ? (occ >= 10'd2 ? LD0 : IDLE) :
              state == LD0 ? WT1 :
              state == WT1 ? LD1 :
              state == LD1 ? (drop ? IDLE : DRAW) :
              (x == x1 ? IDLE : DRAW);
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_n;
  always_ff @(posedge clk)
    if (!reset) begin
      rd_ptr <= '0;
      {buf_sel, line, color} <= '0;
      x <= '0;
      x1 <= '0;
      base <= '0;
      bus.we <= 1'b0;
      bus.addr <= '0;
      bus.data <= '0;
    end else begin
      if (state == LD0) {buf_sel, line, color} <= bus.PRAMdata[15:5];
      if (state == LD0 || state == LD1) rd_ptr <= rd_ptr + 10'd1;
      if (state == LD1) begin
        x <= x0_c;
        x1 <= x1_c;
        base <= base_n;
      end
      if (state == DRAW) x <= x + 8'd1;
      bus.we <= state_n == DRAW;
      if (state_n == DRAW) begin
        bus.addr <= state == LD1 ? base_n + 16'(x0_c) : base + 16'(x) + 16'd1;
        bus.data <= color;
      end
    end
endmodule

// File: doc/span_painter.md
# span_painter

Command-queue consumer that sits between the PRAM command queue and the frame buffers in the draw unit. It reads two-word horizontal-span commands from the 1024-entry PRAM ring through `rdPtr`, and converts each one into a run of single-pixel writes. Each write carries a frame-buffer address, a 3-bit colour and a write enable. The block also owns the queue-full flag that throttles CPU writes.

## Interface
Parameters:
- `WIDTH`, 160: pixels per line.
- `LINES`, 115: lines per RGB buffer.
- `SPECIAL_BASE`, 36800: first address of the special buffer.
- `BACK_OFFSET`, 18400: address offset of the back buffer (`WIDTH*LINES`).

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: the block has one clock; `reset` is synchronous and active-low.
- `wrtPtr`  in  10: CPU write pointer into PRAM.
- `PRAMdata`  in  16: PRAM port-B read data; synchronous read, 1-cycle latency.
- `rdPtr`  out  10: PRAM read address and queue read pointer.
- `full`  out  1: queue full.
- `addr`  out  16: frame-buffer pixel address.
- `data`  out  3: pixel colour {R,G,B}.
- `we`  out  1: frame-buffer write enable.

## Operation
Command format:
- Word0 = {`buf`[15], `line`[14:8], `color`[7:5], reserved[4:0]}.
- Word1 = {`left`[15:8], `right`[7:0]}.

Queue pointers:
- occupancy = (`wrtPtr` − `rdPtr`) mod 1024.
- `full` = ((`wrtPtr` + 1) mod 1024 == `rdPtr`); combinational.
- `rdPtr` increments modulo 1024 and wraps 1023→0 naturally.

State machine (one-hot or binary):
- IDLE: `we`=0. Go to LD0 when occupancy ≥ 2; a lone word0 is never consumed.
- LD0: latch `PRAMdata` as word0; `rdPtr`+1; go to WT1.
- WT1: wait for PRAM data; go to LD1.
- LD1: latch word1; `rdPtr`+1; validate and precompute.
  - If `line` ≥ 120: drop the command and go to IDLE. No pixel is written; both words are still consumed.
  - Otherwise: x0 = min(left,right), x1 = max(left,right), each clamped to 159.
  - Compute base:
    - `line` < 115: `line`*160 + (`buf` ? 18400 : 0).
    - `line` ≥ 115: 36800 + (`line`−115)*160; `buf` is ignored.
  - Go to DRAW with x = x0.
- DRAW: `we`=1, `addr` = base + x, `data` = `color`. If x == x1, go to IDLE; else x+1.

Arithmetic:
- `line`*160 is computed as (`line`<<7)+(`line`<<5) in 16 bits.
- The maximum address is 37599, so there is no overflow.

Outputs:
- `addr`, `data` and `we` are registered.
- `addr` and `data` hold their last value while `we`=0.

## Timing
Reset values (reset low at a rising edge):
- `rdPtr`=0, state IDLE, `we`=0, `addr`=0, `data`=0. x, base, x1 and colour registers are cleared.

Reset mid-command:
- Aborts immediately; no further `we`.
- The PRAM owner must reset `wrtPtr` in the same cycle.

Latency and throughput:
- First `we` is 4 cycles after the first IDLE cycle in which occupancy ≥ 2: LD0, WT1, LD1, then DRAW.
- One pixel per cycle. A span of n pixels occupies 3 + n cycles, plus 1 IDLE cycle, before the next command starts.
- `rdPtr` is stable for ≥1 cycle before each latch, so PRAM data is always valid at LD0 and LD1.

Simultaneous events:
- `wrtPtr` may change in any cycle; occupancy is sampled only in IDLE.
- `full` follows pointer changes in the same cycle.
- When a CPU write and an LD1 increment coincide, `full` reflects both pointers' new values on the next cycle.

## Test plan
- **Reset:** hold reset low 3 cycles with random inputs → `rdPtr`=0, `we`=0, `addr`=0, `data`=0; `full`=0 with `wrtPtr`=0.
- **Basic span:** words 0x0000|color 3'b101 (line 0, buf 0), then 0x0205; `wrtPtr` 0→2 → `we` high exactly 4 cycles, starting 4 cycles after IDLE sees occupancy 2. `addr` 2,3,4,5, `data`=5. `rdPtr` ends at 2.
- **Back buffer, swap, special:**
  - line 10, buf 1, left=right=0 → single write at `addr`=20000.
  - line 117, left 159, right 150 → writes `addr` 37270..37279 in ascending order.
- **Clamp and drop:**
  - left 3, right 200 → last `addr` = base+159.
  - line 121 → zero `we` cycles; `rdPtr` still advances by 2.
- **Wrap and full:**
  - Command at PRAM 1022/1023 → `rdPtr` 1022→1023→0, pixels correct.
  - `wrtPtr`=1023 with `rdPtr`=0 → `full`=1.
  - Single word pending (occupancy 1) → stays IDLE, no `we`.
- **Reset mid-draw:** assert reset on the 3rd pixel of a 10-pixel span → `we`=0 the next cycle, `rdPtr`=0, and no pixel is emitted after reset releases until new commands arrive.
